// File: rtl/motor_phase_sequencer_pkg.sv
// Shared types and constants for the stepper coil sequencer.
package motor_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // {A,B,A_n,B_n} per phase index; entry 0 sits in the low nibble.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Advance the phase by 1 (half step) or 2 (full step); 3-bit arithmetic wraps mod 8.
  function automatic logic [PHASE_W-1:0] next_phase(
    input logic [PHASE_W-1:0] idx,
    input logic               dir,
    input logic               half
  );
    logic [PHASE_W-1:0] inc;
    inc = half ? PHASE_W'(1) : PHASE_W'(2);
    return dir ? idx + inc : idx - inc;
  endfunction

endpackage

// File: rtl/motor_phase_sequencer_tick_prescaler.sv
// Divides clk into one-cycle ticks every PRESCALE cycles; restart re-aligns the phase.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Free-running cycle counter, wrapped on tick and zeroed on restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt_q <= '0;
    else if (restart || tick)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/motor_phase_sequencer.sv
// Stepper phase sequencer: takes a step or pause request, moves the phase
// index, drives the registered coil pattern and times the dwell after it.
module motor_phase_sequencer
  import motor_pkg::*;
#(
  parameter int DELAY_W    = 8,
  parameter int PRESCALE   = 50000,
  parameter int HOLD_TICKS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               step_req,
  input  logic               pause_req,
  input  logic               step_dir,
  input  logic               half_step,
  input  logic [DELAY_W-1:0] delay_ticks,
  output logic               busy,
  output logic               step_done,
  output logic [PHASE_W-1:0] phase_index,
  output logic [3:0]         coil,
  output logic               coil_en
);

  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_d;
  logic [3:0]           coil_d;
  logic                 coil_en_d;
  logic                 dir_q, dir_d, half_q, half_d;
  logic [DELAY_W-1:0]   delay_q, delay_d, dwell_q, dwell_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 restart, tick;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  assign busy      = (state_q != ST_IDLE);
  assign step_done = (state_q == ST_DONE);

  // Next-state, phase, dwell and hold-release decisions.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_index;
    coil_en_d = coil_en;
    dir_d     = dir_q;
    half_d    = half_q;
    delay_d   = delay_q;
    dwell_d   = dwell_q;
    hold_d    = hold_q;
    restart   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Idle ticks accumulate toward releasing the coils; saturates at the limit.
        if (tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (HOLD_TICKS != 0 && hold_q == HOLD_MAX) coil_en_d = 1'b0;
        // Step has priority; a simultaneous pause is simply dropped.
        if (step_req) begin
          dir_d   = step_dir;
          half_d  = half_step;
          delay_d = delay_ticks;
          state_d = ST_STEP;
        end else if (pause_req) begin
          delay_d = delay_ticks;
          dwell_d = delay_ticks;
          restart = 1'b1;
          state_d = ST_DWELL;
        end
      end
      ST_STEP: begin
        phase_d   = next_phase(phase_index, dir_q, half_q);
        coil_en_d = 1'b1;
        hold_d    = '0;
        dwell_d   = delay_q;
        restart   = 1'b1;
        state_d   = ST_DWELL;
      end
      ST_DWELL: begin
        // Leave on the tick that empties the dwell so the wait is exactly delay*PRESCALE.
        if (dwell_q == '0) begin
          state_d = ST_DONE;
        end else if (tick) begin
          dwell_d = dwell_q - 1'b1;
          if (dwell_q == DELAY_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    coil_d = coil_en_d ? COIL_TABLE[phase_d] : 4'b0000;
  end

  // State, datapath and registered coil outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_index <= '0;
      coil        <= 4'b0000;
      coil_en     <= 1'b0;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      delay_q     <= '0;
      dwell_q     <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_index <= phase_d;
      coil        <= coil_d;
      coil_en     <= coil_en_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      delay_q     <= delay_d;
      dwell_q     <= dwell_d;
      hold_q      <= hold_d;
    end
  end

endmodule
